vga_pixel_sink: RTL
===================

Name: vga_pixel_sink

Overview:
- Receiving end of the pixel-write interface (X, Y, Colour, Plot) driven by the keyboard/synth display datapath.
- Stores plotted pixels in a 320x240 x 3-bit frame buffer.
- Scans the buffer out as 640x480@60 VGA, each stored pixel doubled 2x2.
- Provides a clear-to-background sequencer and frame-start pulse for drawing FSMs.

Parameters:
- BACKGROUND, 3'b000, colour written by clear sequence
- H_VIS/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixel ticks (total 800)
- V_VIS/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines (total 525)

Ports:
- iClock  in  1  system clock, 50 MHz
- iReset  in  1  asynchronous reset, active-high
- iX  in  9  write column, valid 0..319
- iY  in  8  write row, valid 0..239
- iColour  in  3  write colour {R,G,B}
- iPlot  in  1  write strobe, one pixel per cycle high
- iClear  in  1  request fill of whole buffer with BACKGROUND
- oColour  out  3  scan-out colour, 0 when blanked
- oHS  out  1  hsync, active-low
- oVS  out  1  vsync, active-low
- oBlank_n  out  1  high in visible region
- oPixEn  out  1  pixel-clock enable (25 MHz tick)
- oBusy  out  1  high while clear sequence runs
- oFrameStart  out  1  one-cycle pulse when scan wraps to (0,0)

Behaviour:
- Reset (async, active-high): tick=0, hCount=0, vCount=0; oColour=0, oHS=1, oVS=1, oBlank_n=0, oPixEn=0, oFrameStart=0. FSM enters CLEAR with clear address 0, so oBusy=1 immediately. RAM contents are not reset.
- Pixel tick: tick toggles every iClock; oPixEn = registered tick. Counters advance only on cycles with tick=1.
  - hCount wraps 799->0; vCount increments on hCount wrap and wraps 524->0.
- Sync generation:
  - oHS low for hCount in [656,751].
  - oVS low for vCount in [490,491].
  - oBlank_n = (hCount<640 && vCount<480).
- Scan address: addr = (vCount>>1)*320 + (hCount>>1), computed as (y<<8)+(y<<6)+x, 17 bits.
- Read port is synchronous, 1 cycle. oHS, oVS, oBlank_n and oColour are registered every iClock and all reflect the same (hCount,vCount), lagging the counters by exactly one iClock.
- oColour = RAM data when blanked-region flag is 1, else 0.
- oFrameStart is high for one iClock, aligned with outputs first showing (0,0).
- Write port, state IDLE:
  - iPlot=1 with iX<320 and iY<240 writes iColour at iY*320+iX on that edge.
  - Out-of-range coordinates are silently dropped.
  - Writes are accepted on every cycle, independent of tick.
- Read/write collision on the same address in the same cycle: read returns old data; the new data is visible on the next read.
- FSM IDLE:
  - iClear=1 -> CLEAR, clear address = 0.
  - iClear and iPlot together: the plot is dropped and the clear starts.
- FSM CLEAR:
  - Writes BACKGROUND to clear address each cycle, address +1.
  - After writing address 76799 -> IDLE. Duration is exactly 76800 cycles; oBusy falls the cycle after the last write.
  - iPlot is ignored while oBusy=1; iClear is ignored (no restart).
- Scan-out continues uninterrupted during CLEAR.
- Reset mid-clear: the clear restarts from address 0.

Test Plan:
- Reset, hold 76800 cycles -> oBusy=1 for exactly 76800 cycles then 0; full frame reads oColour=000 in visible region.
- After clear, plot (0,0)=110 and (319,239)=011 -> screen pixels (0..1,0..1)=110 and (638..639,478..479)=011, all others 000.
- Free-run two frames -> oHS low exactly 96 ticks per 800; oVS low exactly 2 lines per 525; oFrameStart period = 840000 iClocks.
- Plot (320,10) and (5,240) with colour 111 -> no visible change anywhere in the frame.
- Plot same address the scan is reading in that cycle -> that read shows old value; next frame shows new value.
- Assert iReset at clear address ~1000 -> oBusy stays high and exactly 76800 cycles elapse after release before it drops.

Source files
------------

// File: rtl/vga_pixel_sink.sv
// vga_pixel_sink
//   Receiving end of the (X, Y, Colour, Plot) pixel-write interface. Plotted
//   pixels land in a quarter-resolution frame buffer (H_VIS/2 x V_VIS/2,
//   3-bit colour; 320x240 with default timing). The buffer is scanned out as
//   VGA, with every stored pixel doubled 2x2 on screen.
//
//   Ports
//     iClock       system clock (50 MHz; the pixel rate is half of it)
//     iReset       asynchronous reset, active-high
//     iX, iY       write coordinates; out-of-range writes are dropped
//     iColour      write colour {R,G,B}
//     iPlot        write strobe, one pixel per cycle while high
//     iClear       request a fill of the whole buffer with BACKGROUND
//     oColour      scan-out colour, 0 outside the visible region
//     oHS, oVS     horizontal / vertical sync, active-low
//     oBlank_n     high in the visible region
//     oPixEn       pixel-clock enable (registered copy of the half-rate tick)
//     oBusy        high while the clear sequence runs
//     oFrameStart  one-cycle pulse on the first output cycle of pixel (0,0)
//
//   Handshake: there is no back-pressure. A plot is taken on any edge where
//   iPlot=1, oBusy=0, iClear=0 and the coordinates are in range; anything
//   else is dropped silently. iClear is taken only while oBusy=0.
module vga_pixel_sink #(
  parameter logic [2:0] BACKGROUND = 3'b000,
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic       iClock,
  input  logic       iReset,
  input  logic [8:0] iX,
  input  logic [7:0] iY,
  input  logic [2:0] iColour,
  input  logic       iPlot,
  input  logic       iClear,
  output logic [2:0] oColour,
  output logic       oHS,
  output logic       oVS,
  output logic       oBlank_n,
  output logic       oPixEn,
  output logic       oBusy,
  output logic       oFrameStart
);

  localparam int FB_W    = H_VIS / 2;
  localparam int FB_H    = V_VIS / 2;
  localparam int FB_SIZE = FB_W * FB_H;
  localparam int AW      = $clog2(FB_SIZE);

  localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);

  localparam logic [16:0] FB_W_C   = 17'(FB_W);
  localparam logic [16:0] CLR_LAST = 17'(FB_SIZE - 1);
  localparam logic [8:0]  X_LIM    = 9'(FB_W);
  localparam logic [7:0]  Y_LIM    = 8'(FB_H);

  // ---------------------------------------------------------------------
  // Pixel tick and scan counters
  // ---------------------------------------------------------------------
  logic       tick;
  logic [9:0] h_count;
  logic [9:0] v_count;

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      tick    <= 1'b0;
      h_count <= '0;
      v_count <= '0;
    end else begin
      tick <= ~tick;
      if (tick) begin
        if (h_count == H_LAST) begin
          h_count <= '0;
          v_count <= (v_count == V_LAST) ? '0 : v_count + 10'd1;
        end else begin
          h_count <= h_count + 10'd1;
        end
      end
    end
  end

  logic        visible;
  logic [16:0] scan_x;
  logic [16:0] scan_y;
  logic [16:0] scan_addr;
  logic [16:0] rd_addr;

  // Dropping the LSB of each counter gives the 2x2 pixel doubling. With
  // the default width the multiply by 320 reduces to (y<<8)+(y<<6).
  assign visible   = (h_count < H_VIS_C) && (v_count < V_VIS_C);
  assign scan_x    = {8'd0, h_count[9:1]};
  assign scan_y    = {8'd0, v_count[9:1]};
  assign scan_addr = scan_y * FB_W_C + scan_x;
  // Blanking coordinates fall outside the buffer; park the read at 0.
  assign rd_addr   = visible ? scan_addr : 17'd0;

  // ---------------------------------------------------------------------
  // Registered outputs: all reflect the counters of the previous cycle,
  // the same cycle whose address the RAM read uses.
  // ---------------------------------------------------------------------
  logic       hs_q;
  logic       vs_q;
  logic       blank_q;
  logic       pix_en_q;
  logic       fs_q;
  logic [2:0] rd_q;

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      blank_q  <= 1'b0;
      pix_en_q <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      hs_q     <= !((h_count >= HS_FIRST) && (h_count <= HS_LAST));
      vs_q     <= !((v_count >= VS_FIRST) && (v_count <= VS_LAST));
      blank_q  <= visible;
      pix_en_q <= tick;
      // Counters land on (0,0) with tick=0, so this marks the first of the
      // two cycles that pixel (0,0) is shown.
      fs_q     <= (h_count == 10'd0) && (v_count == 10'd0) && !tick;
    end
  end

  assign oHS         = hs_q;
  assign oVS         = vs_q;
  assign oBlank_n    = blank_q;
  assign oPixEn      = pix_en_q;
  assign oFrameStart = fs_q;
  // rd_q is not reset; the blank flag masks it until real data arrives.
  assign oColour     = blank_q ? rd_q : 3'b000;

  // ---------------------------------------------------------------------
  // Write-side FSM: plot in IDLE, sweep the buffer in CLEAR
  // ---------------------------------------------------------------------
  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [16:0] clr_addr;
  logic [16:0] clr_addr_nxt;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [2:0]  wr_data;
  logic [16:0] plot_addr;

  assign plot_addr = {9'd0, iY} * FB_W_C + {8'd0, iX};

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state    <= S_CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    case (state)
      S_IDLE: begin
        // A clear request wins over a simultaneous plot.
        if (iClear) begin
          state_nxt    = S_CLEAR;
          clr_addr_nxt = '0;
        end else if (iPlot && (iX < X_LIM) && (iY < Y_LIM)) begin
          wr_en   = 1'b1;
          wr_addr = plot_addr;
          wr_data = iColour;
        end
      end
      S_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clr_addr;
        wr_data = BACKGROUND;
        if (clr_addr == CLR_LAST) begin
          state_nxt    = S_IDLE;
          clr_addr_nxt = '0;
        end else begin
          clr_addr_nxt = clr_addr + 17'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign oBusy = (state == S_CLEAR);

  // ---------------------------------------------------------------------
  // Frame buffer: one write port, one synchronous read port. The read
  // samples the array before the same-edge write lands (old data wins).
  // ---------------------------------------------------------------------
  logic [2:0] ram [FB_SIZE];

  always_ff @(posedge iClock) begin
    rd_q <= ram[rd_addr[AW-1:0]];
    if (wr_en) ram[wr_addr[AW-1:0]] <= wr_data;
  end

endmodule
